// File: rtl/uart_sha_pkg.sv
// Shared types and sizes for the UART-fed SHA-256 controller.
package uart_sha_pkg;

  localparam int BLOCK_BYTES  = 64;
  localparam int DIGEST_BYTES = 32;

  typedef enum logic [2:0] {
    RX,
    HASH,
    TX_LOAD,
    TX_WAIT_BUSY,
    TX_WAIT_IDLE
  } state_t;

endpackage

// File: rtl/digest_serializer.sv
// Latches a finished digest and hands it to the UART transmitter one byte
// at a time, most significant byte first.
module digest_serializer
  import uart_sha_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] digest,
  input  state_t       state,
  input  logic         tx_busy,
  output logic         tx_send,
  output logic [7:0]   tx_data,
  output logic         last
);

  logic [255:0] digest_q;
  logic [4:0]   byte_idx;

  // The next byte to send always sits in the top of digest_q, so advancing
  // is a left shift rather than a 32-way mux on byte_idx.
  always_ff @(posedge clk) begin
    if (reset) begin
      digest_q <= '0;
      byte_idx <= '0;
      tx_send  <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_send <= 1'b0;
      if (start) begin
        digest_q <= digest;
        byte_idx <= '0;
      end
      if (state == TX_LOAD && !tx_busy) begin
        tx_send <= 1'b1;
        tx_data <= digest_q[255:248];
      end
      if (state == TX_WAIT_IDLE && !tx_busy && !last) begin
        byte_idx <= byte_idx + 5'd1;
        digest_q <= digest_q << 8;
      end
    end
  end

  assign last = (byte_idx == 5'(DIGEST_BYTES - 1));

endmodule

// File: rtl/uart_sha_ctrl.sv
// Collects 64 UART bytes into a SHA-256 block, starts the hash core, then
// streams the 32-byte digest back out through the UART transmitter.
module uart_sha_ctrl
  import uart_sha_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 27000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_ready,
  input  logic [7:0]   rx_data,
  output logic         tx_send,
  output logic [7:0]   tx_data,
  input  logic         tx_busy,
  output logic         sha_start,
  output logic [511:0] sha_block,
  input  logic         sha_done,
  input  logic [255:0] sha_digest,
  output logic         busy,
  output logic         err_timeout,
  output logic         overrun
);

  localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  logic        rx_prev;
  logic [5:0]  byte_cnt;
  logic [31:0] idle_cnt;
  logic        last_byte;

  logic rx_rise;
  logic accept;
  logic block_full;
  logic timeout;
  logic digest_start;

  assign rx_rise      = rx_ready && !rx_prev;
  assign accept       = rx_rise && (state == RX);
  assign block_full   = accept && (byte_cnt == 6'(BLOCK_BYTES - 1));
  // An accepted byte pre-empts a timeout landing on the same cycle.
  assign timeout      = (state == RX) && (byte_cnt != 6'd0) && !accept &&
                        (idle_cnt == IDLE_LAST);
  assign digest_start = (state == HASH) && sha_done;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RX;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
    next_state = state;
    unique case (state)
      RX:           if (block_full)   next_state = HASH;
      HASH:         if (sha_done)     next_state = TX_LOAD;
      TX_LOAD:      if (!tx_busy)     next_state = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (tx_busy)      next_state = TX_WAIT_IDLE;
      TX_WAIT_IDLE: if (!tx_busy)     next_state = last_byte ? RX : TX_LOAD;
      default:                        next_state = RX;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy = (state != RX);
  end

  // Receive datapath: edge detect, block assembly, idle timer and flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // rx_prev starts high so a level already present at reset release is not a byte.
      rx_prev     <= 1'b1;
      byte_cnt    <= '0;
      idle_cnt    <= '0;
      // NOTE: sha_block is a flop bank (not a RAM), so resetting it is cheap and keeps it defined.
      sha_block   <= '0;
      sha_start   <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rx_prev     <= rx_ready;
      sha_start   <= block_full;
      err_timeout <= timeout;
      if (rx_rise && state != RX) overrun <= 1'b1;

      if (accept) begin
        for (int i = 0; i < BLOCK_BYTES; i++) begin
          if (byte_cnt == 6'(i)) sha_block[8*(BLOCK_BYTES-1-i) +: 8] <= rx_data;
        end
        byte_cnt <= block_full ? 6'd0 : byte_cnt + 6'd1;
        idle_cnt <= '0;
      end else if (timeout) begin
        byte_cnt <= '0;
        idle_cnt <= '0;
      end else if (state == RX && byte_cnt != 6'd0) begin
        idle_cnt <= idle_cnt + 32'd1;
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  digest_serializer u_serializer (
    .clk     (clk),
    .reset   (rst),
    .start   (digest_start),
    .digest  (sha_digest),
    .state   (state),
    .tx_busy (tx_busy),
    .tx_send (tx_send),
    .tx_data (tx_data),
    .last    (last_byte)
  );

endmodule

// File: tb/tb_uart_sha_ctrl.sv
// Directed bench for uart_sha_ctrl with a stub SHA core and a stub UART
// transmitter; expected values are hand-derived from the "abc" vector.
module tb_uart_sha_ctrl;

  localparam int TIMEOUT = 100;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         clk;
  logic         rst;
  logic         rx_ready;
  logic [7:0]   rx_data;
  logic         tx_send;
  logic [7:0]   tx_data;
  logic         tx_busy;
  logic         sha_start;
  logic [511:0] sha_block;
  logic         sha_done;
  logic [255:0] sha_digest;
  logic         busy;
  logic         err_timeout;
  logic         overrun;

  uart_sha_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .tx_send     (tx_send),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .sha_start   (sha_start),
    .sha_block   (sha_block),
    .sha_done    (sha_done),
    .sha_digest  (sha_digest),
    .busy        (busy),
    .err_timeout (err_timeout),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_err    = 0;
  int n_start  = 0;
  int n_send   = 0;

  logic [7:0] blk       [64];
  logic [7:0] exp_bytes [32];
  logic [7:0] got_bytes [32];
  int         got_n;

  // Pulse counters, sampled shortly after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (err_timeout) n_err++;
    if (sha_start)   n_start++;
    if (tx_send)     n_send++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic load_abc();
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    blk[0]  = 8'h61;
    blk[1]  = 8'h62;
    blk[2]  = 8'h63;
    blk[3]  = 8'h80;
    blk[63] = 8'h18;
  endtask

  function automatic logic [511:0] blk_vec();
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) v = {v[503:0], blk[i]};
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, output logic start_seen);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready   = 1'b0;
    start_seen = sha_start;
  endtask

  task automatic send_block(input int first, output int early, output logic last_start);
    logic s;
    early      = 0;
    last_start = 1'b0;
    for (int i = first; i < 64; i++) begin
      send_byte(blk[i], s);
      if (i < 63 && s) early++;
      if (i == 63) last_start = s;
    end
  endtask

  task automatic respond_sha();
    repeat (4) @(negedge clk);
    sha_digest = ABC_DIGEST;
    sha_done   = 1'b1;
    @(negedge clk);
    sha_done   = 1'b0;
    sha_digest = '0;
  endtask

  task automatic collect(input int want);
    int cyc;
    cyc   = 0;
    got_n = 0;
    for (int i = 0; i < 32; i++) got_bytes[i] = 8'h00;
    while (got_n < want && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (tx_send) begin
        got_bytes[got_n] = tx_data;
        got_n++;
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    int e0, s0;
    rst = 1'b1; rx_ready = 1'b1; rx_data = 8'h5a;
    repeat (3) @(negedge clk);
    n_checks++; if (tx_send !== 1'b0)     $display("FAIL reset_tx_send: got %b want 0", tx_send);         else n_pass++;
    n_checks++; if (sha_start !== 1'b0)   $display("FAIL reset_sha_start: got %b want 0", sha_start);     else n_pass++;
    n_checks++; if (err_timeout !== 1'b0) $display("FAIL reset_err_timeout: got %b want 0", err_timeout); else n_pass++;
    n_checks++; if (overrun !== 1'b0)     $display("FAIL reset_overrun: got %b want 0", overrun);         else n_pass++;
    n_checks++; if (busy !== 1'b0)        $display("FAIL reset_busy: got %b want 0", busy);               else n_pass++;
    n_checks++; if (tx_data !== 8'h00)    $display("FAIL reset_tx_data: got %h want 00", tx_data);        else n_pass++;
    n_checks++; if (sha_block !== '0)     $display("FAIL reset_sha_block: got %h want 0", sha_block);     else n_pass++;
    // rx_ready stays high across release: must not count as a byte, so no idle timer runs.
    e0 = n_err;
    rst = 1'b0;
    repeat (150) @(negedge clk);
    rx_ready = 1'b0;
    n_checks++; if (n_err - e0 !== 0)  $display("FAIL reset_level_counted: err pulses got %0d want 0", n_err - e0); else n_pass++;
    n_checks++; if (overrun !== 1'b0)  $display("FAIL reset_level_overrun: got %b want 0", overrun);                else n_pass++;
    // A stray sha_done in RX must be ignored.
    s0 = n_send;
    @(negedge clk);
    sha_digest = ABC_DIGEST; sha_done = 1'b1;
    @(negedge clk);
    sha_done = 1'b0; sha_digest = '0;
    repeat (10) @(negedge clk);
    n_checks++; if (busy !== 1'b0)      $display("FAIL stray_done_busy: got %b want 0", busy);                 else n_pass++;
    n_checks++; if (n_send - s0 !== 0)  $display("FAIL stray_done_send: got %0d sends want 0", n_send - s0);   else n_pass++;
  endtask

  task automatic test_abc();
    int early, s0, t0;
    logic last_start;
    load_abc();
    s0 = n_start; t0 = n_send;
    send_block(0, early, last_start);
    n_checks++; if (early !== 0)           $display("FAIL abc_early_start: got %0d want 0", early);           else n_pass++;
    n_checks++; if (last_start !== 1'b1)   $display("FAIL abc_start_on_64: got %b want 1", last_start);       else n_pass++;
    n_checks++; if (n_start - s0 !== 1)    $display("FAIL abc_start_pulses: got %0d want 1", n_start - s0);   else n_pass++;
    n_checks++; if (busy !== 1'b1)         $display("FAIL abc_busy_hash: got %b want 1", busy);               else n_pass++;
    n_checks++; if (sha_block !== blk_vec()) $display("FAIL abc_block: got %h want %h", sha_block, blk_vec()); else n_pass++;
    respond_sha();
    collect(32);
    n_checks++; if (sha_block !== blk_vec()) $display("FAIL abc_block_stable: got %h want %h", sha_block, blk_vec()); else n_pass++;
    n_checks++; if (got_n !== 32)          $display("FAIL abc_tx_count: got %0d want 32", got_n);             else n_pass++;
    for (int i = 0; i < 32; i++) begin
      n_checks++; if (got_bytes[i] !== exp_bytes[i]) $display("FAIL abc_tx_byte%0d: got %h want %h", i, got_bytes[i], exp_bytes[i]); else n_pass++;
    end
    n_checks++; if (n_send - t0 !== 32)    $display("FAIL abc_tx_pulses: got %0d want 32", n_send - t0);      else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)         $display("FAIL abc_back_to_rx: busy got %b want 0", busy);         else n_pass++;
  endtask

  task automatic test_held_level();
    int early;
    logic last_start;
    load_abc();
    blk[0] = 8'h41;
    @(negedge clk);
    rx_data = 8'h41; rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    rx_ready = 1'b0;
    send_block(1, early, last_start);
    n_checks++; if (early !== 0)           $display("FAIL held_early_start: got %0d want 0", early);         else n_pass++;
    n_checks++; if (last_start !== 1'b1)   $display("FAIL held_start_on_64: got %b want 1", last_start);     else n_pass++;
    n_checks++; if (sha_block !== blk_vec()) $display("FAIL held_block: got %h want %h", sha_block, blk_vec()); else n_pass++;
    respond_sha();
    collect(32);
    n_checks++; if (got_n !== 32)          $display("FAIL held_tx_count: got %0d want 32", got_n);           else n_pass++;
    n_checks++; if (got_bytes[31] !== 8'had) $display("FAIL held_tx_last: got %h want ad", got_bytes[31]);    else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)         $display("FAIL held_back_to_rx: busy got %b want 0", busy);       else n_pass++;
  endtask

  task automatic test_timeout();
    int e0, e1, cyc, early;
    logic s, last_start;
    e0 = n_err;
    for (int i = 0; i < 10; i++) send_byte(8'h10 + 8'(i), s);
    cyc = 0;
    while (!err_timeout && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (cyc !== TIMEOUT)       $display("FAIL timeout_latency: got %0d cycles want %0d", cyc, TIMEOUT); else n_pass++;
    repeat (50) @(negedge clk);
    n_checks++; if (n_err - e0 !== 1)      $display("FAIL timeout_pulses: got %0d want 1", n_err - e0);      else n_pass++;
    n_checks++; if (busy !== 1'b0)         $display("FAIL timeout_busy: got %b want 0", busy);               else n_pass++;
    // Byte landing on the exact timeout cycle wins.
    e1 = n_err;
    send_byte(8'ha0, s); send_byte(8'ha1, s); send_byte(8'ha2, s);
    repeat (TIMEOUT - 2) @(negedge clk);
    send_byte(8'hc3, s);
    n_checks++; if (err_timeout !== 1'b0)  $display("FAIL collide_err: got %b want 0", err_timeout);         else n_pass++;
    n_checks++; if (sha_block[487:480] !== 8'hc3) $display("FAIL collide_store: got %h want c3", sha_block[487:480]); else n_pass++;
    repeat (150) @(negedge clk);
    n_checks++; if (n_err - e1 !== 1)      $display("FAIL collide_later_timeout: got %0d want 1", n_err - e1); else n_pass++;
    // After the discard, a full block starts again at byte 0.
    load_abc();
    send_block(0, early, last_start);
    n_checks++; if (early !== 0)           $display("FAIL after_timeout_early: got %0d want 0", early);      else n_pass++;
    n_checks++; if (last_start !== 1'b1)   $display("FAIL after_timeout_start: got %b want 1", last_start);  else n_pass++;
    n_checks++; if (sha_block !== blk_vec()) $display("FAIL after_timeout_block: got %h want %h", sha_block, blk_vec()); else n_pass++;
    respond_sha();
    collect(32);
    n_checks++; if (got_n !== 32)          $display("FAIL after_timeout_tx_count: got %0d want 32", got_n);  else n_pass++;
    for (int i = 0; i < 32; i++) begin
      n_checks++; if (got_bytes[i] !== exp_bytes[i]) $display("FAIL after_timeout_byte%0d: got %h want %h", i, got_bytes[i], exp_bytes[i]); else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    int early;
    logic s, last_start;
    n_checks++; if (overrun !== 1'b0)      $display("FAIL overrun_pre: got %b want 0", overrun);             else n_pass++;
    load_abc();
    send_block(0, early, last_start);
    send_byte(8'hee, s);
    n_checks++; if (overrun !== 1'b1)      $display("FAIL overrun_set: got %b want 1", overrun);             else n_pass++;
    n_checks++; if (sha_block !== blk_vec()) $display("FAIL overrun_block: got %h want %h", sha_block, blk_vec()); else n_pass++;
    n_checks++; if (busy !== 1'b1)         $display("FAIL overrun_busy: got %b want 1", busy);               else n_pass++;
    respond_sha();
    collect(32);
    n_checks++; if (got_n !== 32)          $display("FAIL overrun_tx_count: got %0d want 32", got_n);        else n_pass++;
    n_checks++; if (got_bytes[0] !== 8'hba) $display("FAIL overrun_tx_first: got %h want ba", got_bytes[0]); else n_pass++;
    n_checks++; if (overrun !== 1'b1)      $display("FAIL overrun_sticky: got %b want 1", overrun);          else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_tx();
    int early, s0;
    logic last_start;
    load_abc();
    send_block(0, early, last_start);
    respond_sha();
    collect(5);
    n_checks++; if (got_n !== 5)           $display("FAIL midreset_partial: got %0d want 5", got_n);         else n_pass++;
    s0 = n_send;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    n_checks++; if (n_send - s0 !== 0)     $display("FAIL midreset_no_send: got %0d want 0", n_send - s0);   else n_pass++;
    n_checks++; if (busy !== 1'b0)         $display("FAIL midreset_state: busy got %b want 0", busy);        else n_pass++;
    n_checks++; if (overrun !== 1'b0)      $display("FAIL midreset_overrun: got %b want 0", overrun);        else n_pass++;
    send_block(0, early, last_start);
    n_checks++; if (early !== 0)           $display("FAIL midreset_early: got %0d want 0", early);           else n_pass++;
    n_checks++; if (last_start !== 1'b1)   $display("FAIL midreset_start: got %b want 1", last_start);       else n_pass++;
    respond_sha();
    collect(32);
    n_checks++; if (got_n !== 32)          $display("FAIL midreset_tx_count: got %0d want 32", got_n);       else n_pass++;
    for (int i = 0; i < 32; i++) begin
      n_checks++; if (got_bytes[i] !== exp_bytes[i]) $display("FAIL midreset_byte%0d: got %h want %h", i, got_bytes[i], exp_bytes[i]); else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_busy_hold();
    int early, s0;
    logic last_start;
    load_abc();
    send_block(0, early, last_start);
    tx_busy = 1'b1;
    respond_sha();
    s0 = n_send;
    repeat (1000) @(negedge clk);
    n_checks++; if (n_send - s0 !== 0)     $display("FAIL hold_no_send: got %0d want 0", n_send - s0);       else n_pass++;
    n_checks++; if (busy !== 1'b1)         $display("FAIL hold_busy: got %b want 1", busy);                  else n_pass++;
    tx_busy = 1'b0;
    collect(32);
    n_checks++; if (got_n !== 32)          $display("FAIL hold_tx_count: got %0d want 32", got_n);           else n_pass++;
    n_checks++; if (n_send - s0 !== 32)    $display("FAIL hold_tx_pulses: got %0d want 32", n_send - s0);    else n_pass++;
    n_checks++; if (got_bytes[0] !== 8'hba) $display("FAIL hold_tx_first: got %h want ba", got_bytes[0]);    else n_pass++;
    n_checks++; if (got_bytes[1] !== 8'h78) $display("FAIL hold_tx_second: got %h want 78", got_bytes[1]);   else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)         $display("FAIL hold_back_to_rx: busy got %b want 0", busy);       else n_pass++;
  endtask

  initial begin
    logic [255:0] d;
    rst = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    sha_done = 1'b0; sha_digest = '0;
    d = ABC_DIGEST;
    for (int i = 0; i < 32; i++) begin
      exp_bytes[i] = d[255:248];
      d = d << 8;
    end

    test_reset();
    test_abc();
    test_held_level();
    test_timeout();
    test_overrun();
    test_reset_mid_tx();
    test_busy_hold();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
